field_write_arbiter: RTL and testbench
======================================

// Module: field_write_arbiter
// PURPOSE
//  Owns one shared REG_W-bit register and serialises part-select (bit-field) writes
//  from NREQ requesters. Arbitration is round-robin.
//  Each write is a masked read-modify-write of bits [msb:lsb]. Bits outside the field
//  are preserved.
//  Provides a combinational part-select read port (reg[rd_msb:rd_lsb], right-aligned).
//  Sits between control requesters and any logic consuming reg_q or field slices.
// PARAMETERS
//  REG_W     8      width of shared register
//  NREQ      2      number of write requesters (>=1)
//  POS_W     3      bit-index width, $clog2(REG_W)
//  RESET_VAL 8'h00  register value on reset (REG_W bits)
// PORTS
//  clk        in   1             rising-edge clock
//  rst_n      in   1             asynchronous reset, active-low
//  req_valid  in   NREQ          write request per requester
//  req_ready  out  NREQ          grant/accept, one-hot or zero
//  req_msb    in   NREQ*POS_W    field msb; requester i at [i*POS_W +: POS_W]
//  req_lsb    in   NREQ*POS_W    field lsb; same packing
//  req_data   in   NREQ*REG_W    right-aligned field value; requester i at [i*REG_W +: REG_W]
//  rd_msb     in   POS_W         read field msb
//  rd_lsb     in   POS_W         read field lsb
//  rd_data    out  REG_W         reg_q[rd_msb:rd_lsb] right-aligned, zero-extended
//  reg_q      out  REG_W         current register value
//  upd        out  1             one-cycle pulse: a write committed this cycle
//  err        out  1             one-cycle pulse: write rejected (msb<lsb)
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - reg_q=RESET_VAL; state=IDLE; rr_ptr=0; upd=0; err=0; req_ready=0.
//   - Any latched request is discarded.
//  FSM, two states:
//   - IDLE: search req_valid starting at rr_ptr, wrapping modulo NREQ; pick the first
//     set bit g. req_ready[g]=1 combinationally in the same cycle. The handshake
//     completes on that edge. Latch msb/lsb/data of g and go to COMMIT.
//     With no valid, req_ready=0 and stay in IDLE.
//   - COMMIT: req_ready=0. If msb>=lsb:
//       mask = ones over [msb:lsb]
//       reg_q <= (reg_q & ~mask) | ((data<<lsb) & mask)
//     upd=1 this cycle. The new value is visible from the next cycle.
//     If msb<lsb: reg_q unchanged, err=1, upd=0.
//     In both cases rr_ptr <= (g+1) % NREQ, then go to IDLE.
//  Throughput and latency:
//   - Throughput: one write per 2 cycles.
//   - Latency: valid sampled at edge N (IDLE) -> reg_q updated after edge N+1.
//  Requester rules: hold valid and fields stable until ready; valid may drop only after
//   the handshake. Non-granted requesters wait; no starvation, since each waits at most
//   NREQ-1 grants.
//  Data bits of req_data above the field width are ignored (truncation, no error).
//  rd_data is combinational from reg_q: bits above (rd_msb-rd_lsb) are 0.
//   If rd_msb<rd_lsb, rd_data=0.
//  Fields that equal the full register ([REG_W-1:0]) are legal and replace all bits.
//  Reset asserted during COMMIT: the pending write is lost; upd is not asserted.
// TESTING
//  1 Hold rst_n=0, release -> reg_q=00, req_ready=0, upd=0, err=0.
//  2 req0 [7:0]=8'h42 -> ready0 1 cycle, upd pulse next cycle; reg_q=42;
//    rd[5:4]=2'b00.
//  3 req0 [5:3]=3'b111 -> reg_q=7A; rd[5:4]=2'b11; rd[7:7]=0;
//    then req1 [1:0] data=FF -> reg_q=7B.
//  4 From rr_ptr=0, req0 [3:0]=F and req1 [3:0]=0 both valid ->
//    grant order req0 then req1; reg low nibble F then 0; rr_ptr returns to 0.
//  5 req1 msb=2 lsb=5 -> err pulse, upd=0, reg_q unchanged; rr_ptr advances.
//  6 Pulse rst_n low during COMMIT of req0 [7:0]=AA -> reg_q=00, no upd,
//    FSM idle, ready=0.

Source files
------------

// File: rtl/field_write_arbiter.sv
// Shared register with round-robin arbitration of masked bit-field writes.
// Each accepted write takes one IDLE (grant) cycle plus one COMMIT cycle.
module field_write_arbiter #(
    parameter int               REG_W     = 8,
    parameter int               NREQ      = 2,
    parameter int               POS_W     = $clog2(REG_W),
    parameter logic [REG_W-1:0] RESET_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*POS_W-1:0]   req_msb,
    input  logic [NREQ*POS_W-1:0]   req_lsb,
    input  logic [NREQ*REG_W-1:0]   req_data,
    input  logic [POS_W-1:0]        rd_msb,
    input  logic [POS_W-1:0]        rd_lsb,
    output logic [REG_W-1:0]        rd_data,
    output logic [REG_W-1:0]        reg_q,
    output logic                    upd,
    output logic                    err
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE, COMMIT} state_t;

    state_t             state_q, state_d;
    logic [REG_W-1:0]   reg_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   gnt_q, gnt_d;
    logic [POS_W-1:0]   msb_q, msb_d;
    logic [POS_W-1:0]   lsb_q, lsb_d;
    logic [REG_W-1:0]   data_q, data_d;
    logic               upd_q, upd_d;
    logic               err_q, err_d;

    logic               grant_found;
    logic [IDX_W-1:0]   grant_idx;
    logic [POS_W-1:0]   grant_msb;
    logic [POS_W-1:0]   grant_lsb;
    logic [REG_W-1:0]   grant_data;
    logic [REG_W-1:0]   field_mask;
    logic [REG_W-1:0]   rd_shift;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_found && req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'((int'(rr_ptr_q) + k) % NREQ);
            end
        end
        grant_msb  = req_msb[int'(grant_idx)*POS_W +: POS_W];
        grant_lsb  = req_lsb[int'(grant_idx)*POS_W +: POS_W];
        grant_data = req_data[int'(grant_idx)*REG_W +: REG_W];
        req_ready  = '0;
        if (state_q == IDLE && grant_found && rst_n) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        field_mask = '0;
        for (int i = 0; i < REG_W; i++) begin
            field_mask[i] = (i >= int'(lsb_q)) && (i <= int'(msb_q));
        end
    end

    always_comb begin
        rd_shift = reg_q >> rd_lsb;
        rd_data  = '0;
        if (rd_msb >= rd_lsb) begin
            for (int i = 0; i < REG_W; i++) begin
                if (i <= int'(rd_msb) - int'(rd_lsb)) begin
                    rd_data[i] = rd_shift[i];
                end
            end
        end
    end

    // upd/err are decided at grant time so they are registered and high for the COMMIT cycle.
    always_comb begin
        state_d  = state_q;
        reg_d    = reg_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        msb_d    = msb_q;
        lsb_d    = lsb_q;
        data_d   = data_q;
        upd_d    = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    gnt_d   = grant_idx;
                    msb_d   = grant_msb;
                    lsb_d   = grant_lsb;
                    data_d  = grant_data;
                    upd_d   = (grant_msb >= grant_lsb);
                    err_d   = (grant_msb <  grant_lsb);
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                if (msb_q >= lsb_q) begin
                    reg_d = (reg_q & ~field_mask) | ((data_q << lsb_q) & field_mask);
                end
                rr_ptr_d = (int'(gnt_q) == NREQ - 1) ? '0 : gnt_q + 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            reg_q    <= RESET_VAL;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            msb_q    <= '0;
            lsb_q    <= '0;
            data_q   <= '0;
            upd_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            reg_q    <= reg_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            msb_q    <= msb_d;
            lsb_q    <= lsb_d;
            data_q   <= data_d;
            upd_q    <= upd_d;
            err_q    <= err_d;
        end
    end

    assign upd = upd_q;
    assign err = err_q;

endmodule

// File: tb/tb_field_write_arbiter.sv
// Self-checking bench for field_write_arbiter: directed vector table, random
// traffic against a transaction-level model, and reset during a commit.
module tb_field_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [5:0]  req_msb = '0;
    logic [5:0]  req_lsb = '0;
    logic [15:0] req_data = '0;
    logic [2:0]  rd_msb = '0;
    logic [2:0]  rd_lsb = '0;
    logic [7:0]  rd_data;
    logic [7:0]  reg_q;
    logic        upd;
    logic        err;

    int total = 0;
    int bad   = 0;

    field_write_arbiter #(.REG_W(8), .NREQ(2), .POS_W(3), .RESET_VAL(8'h00)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_msb(req_msb), .req_lsb(req_lsb), .req_data(req_data),
        .rd_msb(rd_msb), .rd_lsb(rd_lsb), .rd_data(rd_data),
        .reg_q(reg_q), .upd(upd), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] valid;
        logic [2:0] msb0;
        logic [2:0] lsb0;
        logic [7:0] data0;
        logic [2:0] msb1;
        logic [2:0] lsb1;
        logic [7:0] data1;
        logic [2:0] rd_msb;
        logic [2:0] rd_lsb;
        int         exp_grant;
        logic [7:0] exp_reg;
        logic       exp_err;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs[11];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Field semantics written with plain integer masks, independent of the RTL.
    function automatic logic [7:0] model_write(input logic [7:0] r, input int msb, input int lsb, input int data);
        int mask;
        int rv;
        if (msb < lsb) return r;
        mask = ((1 << (msb + 1)) - 1) - ((1 << lsb) - 1);
        rv   = int'(r);
        return 8'((rv & ~mask) | ((data << lsb) & mask));
    endfunction

    function automatic logic [7:0] model_read(input logic [7:0] r, input int msb, input int lsb);
        if (msb < lsb) return 8'h00;
        return 8'((int'(r) >> lsb) & ((1 << (msb - lsb + 1)) - 1));
    endfunction

    // Entered and left just after a falling edge; one grant+commit or one idle cycle.
    task automatic apply_stimulus(input vec_t v, input logic [7:0] old_reg, input string tag);
        req_valid = v.valid;
        req_msb   = {v.msb1, v.msb0};
        req_lsb   = {v.lsb1, v.lsb0};
        req_data  = {v.data1, v.data0};
        rd_msb    = v.rd_msb;
        rd_lsb    = v.rd_lsb;
        #1;
        check_output({tag, " ready"}, 32'(req_ready),
                     (v.exp_grant < 0) ? 32'd0 : 32'(1 << v.exp_grant));
        check_output({tag, " upd_idle"}, 32'(upd), 32'd0);
        @(posedge clk);
        @(negedge clk);
        if (v.exp_grant >= 0) begin
            req_valid[v.exp_grant] = 1'b0;
            #1;
            check_output({tag, " ready_commit"}, 32'(req_ready), 32'd0);
            check_output({tag, " upd"}, 32'(upd), 32'(!v.exp_err));
            check_output({tag, " err"}, 32'(err), 32'(v.exp_err));
            check_output({tag, " reg_commit"}, 32'(reg_q), 32'(old_reg));
            @(posedge clk);
            @(negedge clk);
        end else begin
            check_output({tag, " err_idle"}, 32'(err), 32'd0);
        end
        check_output({tag, " reg"}, 32'(reg_q), 32'(v.exp_reg));
        check_output({tag, " rd"}, 32'(rd_data), 32'(v.exp_rd));
    endtask

    initial begin
        logic [7:0] m_reg;
        int         m_rr;
        logic       pend[2];
        int         pm[2];
        int         pl[2];
        int         pd[2];
        int         win;
        int         idx;
        vec_t       v;

        //                valid  msb0  lsb0  data0  msb1  lsb1  data1  rdm   rdl  grant reg    err   rd
        vecs[0]  = '{2'b01, 3'd7, 3'd0, 8'h42, 3'd0, 3'd0, 8'h00, 3'd5, 3'd4,  0, 8'h42, 1'b0, 8'h00};
        vecs[1]  = '{2'b01, 3'd5, 3'd3, 8'h07, 3'd0, 3'd0, 8'h00, 3'd5, 3'd4,  0, 8'h7A, 1'b0, 8'h03};
        vecs[2]  = '{2'b00, 3'd0, 3'd0, 8'h00, 3'd0, 3'd0, 8'h00, 3'd7, 3'd7, -1, 8'h7A, 1'b0, 8'h00};
        vecs[3]  = '{2'b10, 3'd0, 3'd0, 8'h00, 3'd1, 3'd0, 8'hFF, 3'd7, 3'd0,  1, 8'h7B, 1'b0, 8'h7B};
        vecs[4]  = '{2'b11, 3'd3, 3'd0, 8'h0F, 3'd3, 3'd0, 8'h00, 3'd3, 3'd0,  0, 8'h7F, 1'b0, 8'h0F};
        vecs[5]  = '{2'b11, 3'd3, 3'd0, 8'h0F, 3'd3, 3'd0, 8'h00, 3'd6, 3'd4,  1, 8'h70, 1'b0, 8'h07};
        vecs[6]  = '{2'b11, 3'd7, 3'd4, 8'h03, 3'd0, 3'd0, 8'h01, 3'd7, 3'd4,  0, 8'h30, 1'b0, 8'h03};
        vecs[7]  = '{2'b10, 3'd0, 3'd0, 8'h00, 3'd2, 3'd5, 8'hFF, 3'd2, 3'd5,  1, 8'h30, 1'b1, 8'h00};
        vecs[8]  = '{2'b11, 3'd0, 3'd0, 8'h01, 3'd1, 3'd1, 8'h01, 3'd5, 3'd0,  0, 8'h31, 1'b0, 8'h31};
        vecs[9]  = '{2'b10, 3'd0, 3'd0, 8'h00, 3'd3, 3'd0, 8'hA5, 3'd2, 3'd1,  1, 8'h35, 1'b0, 8'h02};
        vecs[10] = '{2'b11, 3'd7, 3'd4, 8'h05, 3'd3, 3'd0, 8'h09, 3'd7, 3'd0,  0, 8'h50, 1'b0, 8'h50};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("rst reg", 32'(reg_q), 32'h00);
        check_output("rst ready", 32'(req_ready), 32'd0);
        check_output("rst upd", 32'(upd), 32'd0);
        check_output("rst err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("post_rst reg", 32'(reg_q), 32'h00);
        check_output("post_rst ready", 32'(req_ready), 32'd0);
        check_output("post_rst upd", 32'(upd), 32'd0);
        check_output("post_rst err", 32'(err), 32'd0);

        m_reg = 8'h00;
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(vecs[i], m_reg, $sformatf("vec%0d", i));
            m_reg = vecs[i].exp_reg;
        end

        m_rr = 0;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 1'b0; pm[i] = 0; pl[i] = 0; pd[i] = 0;
        end
        for (int it = 0; it < 300; it++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(1, 0) == 1) begin
                    pend[i] = 1'b1;
                    pm[i]   = int'($urandom_range(7, 0));
                    pl[i]   = int'($urandom_range(7, 0));
                    pd[i]   = int'($urandom_range(255, 0));
                end
            end
            req_valid = {pend[1], pend[0]};
            req_msb   = {3'(pm[1]), 3'(pm[0])};
            req_lsb   = {3'(pl[1]), 3'(pl[0])};
            req_data  = {8'(pd[1]), 8'(pd[0])};
            rd_msb    = 3'($urandom_range(7, 0));
            rd_lsb    = 3'($urandom_range(7, 0));
            #1;
            win = -1;
            for (int k = 0; k < 2; k++) begin
                idx = (m_rr + k) % 2;
                if (win < 0 && pend[idx]) win = idx;
            end
            check_output("rnd ready", 32'(req_ready), (win < 0) ? 32'd0 : 32'(1 << win));
            check_output("rnd reg", 32'(reg_q), 32'(m_reg));
            check_output("rnd rd", 32'(rd_data), 32'(model_read(m_reg, int'(rd_msb), int'(rd_lsb))));
            check_output("rnd upd_idle", 32'(upd), 32'd0);
            @(posedge clk);
            @(negedge clk);
            if (win >= 0) begin
                pend[win] = 1'b0;
                req_valid[win] = 1'b0;
                #1;
                check_output("rnd ready_commit", 32'(req_ready), 32'd0);
                check_output("rnd upd", 32'(upd), 32'(pm[win] >= pl[win]));
                check_output("rnd err", 32'(err), 32'(pm[win] < pl[win]));
                m_reg = model_write(m_reg, pm[win], pl[win], pd[win]);
                m_rr  = (win + 1) % 2;
                @(posedge clk);
                @(negedge clk);
            end
        end
        check_output("rnd final reg", 32'(reg_q), 32'(m_reg));

        // Reset arriving while a write sits in COMMIT must drop it.
        req_valid = 2'b01;
        req_msb   = {3'd0, 3'd7};
        req_lsb   = {3'd0, 3'd0};
        req_data  = {8'h00, 8'hAA};
        rd_msb    = 3'd7;
        rd_lsb    = 3'd0;
        #1;
        check_output("rstc ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        @(negedge clk);
        check_output("rstc upd_before", 32'(upd), 32'd1);
        rst_n = 1'b0;
        #1;
        check_output("rstc reg", 32'(reg_q), 32'h00);
        check_output("rstc upd", 32'(upd), 32'd0);
        check_output("rstc ready_in_rst", 32'(req_ready), 32'd0);
        req_valid = 2'b00;
        @(posedge clk);
        @(negedge clk);
        check_output("rstc reg_hold", 32'(reg_q), 32'h00);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_output("rstc reg_after", 32'(reg_q), 32'h00);
        check_output("rstc upd_after", 32'(upd), 32'd0);
        check_output("rstc ready_after", 32'(req_ready), 32'd0);
        v = vecs[10];
        apply_stimulus(v, 8'h00, "rstc_next");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
